// File: rtl/pmod_adc_pkg.sv
// Shared constants for the multi-channel AD7476A-style reader: default timing
// for a 100 MHz system clock and the sampler state encoding.
package pmod_adc_pkg;

    localparam int SCLK_HALF_100M = 4000;
    localparam int AD7476_FRAME   = 16;
    localparam int AD7476_BITS    = 12;
    localparam int AD7476_QUIET   = 4;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_CONV  = 2'd1;
    localparam logic [1:0] ST_QUIET = 2'd2;

endpackage

// File: rtl/sclk_gen.sv
// SCLK divider: toggles every SCLK_HALF cycles, first toggle falling.
// Held high with its divider at zero while cleared.
import pmod_adc_pkg::*;

module sclk_gen #(
    parameter int SCLK_HALF = SCLK_HALF_100M
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clr,
    output logic o_sclk,
    output logic o_rise_tick,
    output logic o_fall_tick
);

    localparam int                DIV_W    = $clog2(SCLK_HALF + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCLK_HALF - 1);

    logic [DIV_W-1:0] r_div;
    logic             r_sclk;
    logic             w_tick;

    assign w_tick = !i_clr && (r_div == DIV_LAST);

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_div  <= '0;
            r_sclk <= 1'b1;
        end else if (w_tick) begin
            r_div  <= '0;
            r_sclk <= ~r_sclk;
        end else begin
            r_div  <= r_div + 1'b1;
        end
    end

    // Ticks mark the cycle whose closing edge changes the SCLK level.
    assign o_sclk      = r_sclk;
    assign o_rise_tick = w_tick && !r_sclk;
    assign o_fall_tick = w_tick && r_sclk;

endmodule

// File: rtl/pmod_adc_multi_reader.sv
// Reads N_CH serial ADCs over a shared CS/SCLK pair, presents registered
// parallel samples with a VALID strobe and per-channel threshold-crossing hits.
import pmod_adc_pkg::*;

module pmod_adc_multi_reader #(
    parameter int N_CH       = 2,
    parameter int SCLK_HALF  = SCLK_HALF_100M,
    parameter int FRAME_BITS = AD7476_FRAME,
    parameter int DATA_BITS  = AD7476_BITS,
    parameter int QUIET_CYC  = AD7476_QUIET
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_en,
    input  logic                      i_single,
    input  logic                      i_start,
    input  logic [N_CH-1:0]           i_sdata,
    input  logic [DATA_BITS-1:0]      i_thresh,
    output logic                      o_cs,
    output logic                      o_sclk,
    output logic [N_CH*DATA_BITS-1:0] o_data,
    output logic                      o_valid,
    output logic                      o_busy,
    output logic [N_CH-1:0]           o_hit,
    output logic [1:0]                o_dbg_state
);

    localparam int                CNT_W    = $clog2(FRAME_BITS + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_BITS);
    localparam int                Q_W      = $clog2(QUIET_CYC + 1);
    localparam logic [Q_W-1:0]   Q_LAST   = Q_W'(QUIET_CYC - 1);

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [CNT_W-1:0] r_bit_cnt;
    logic [Q_W-1:0]   r_quiet_cnt;
    logic             r_valid;
    logic             w_frame_done;
    logic             w_sclk_clr;
    logic             w_sclk;
    logic             w_rise_tick;
    logic             w_fall_tick;
    logic             w_unused_fall;

    // The divider is released only while bits remain, so SCLK parks high
    // after the last rising edge even when SCLK_HALF is 1.
    assign w_frame_done = (r_state == ST_CONV) && (r_bit_cnt == CNT_LAST);
    assign w_sclk_clr   = (r_state != ST_CONV) || (r_bit_cnt == CNT_LAST);
    assign w_unused_fall = w_fall_tick;

    sclk_gen #(
        .SCLK_HALF (SCLK_HALF)
    ) u_sclk_gen (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_clr       (w_sclk_clr),
        .o_sclk      (w_sclk),
        .o_rise_tick (w_rise_tick),
        .o_fall_tick (w_fall_tick)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (i_en && (!i_single || i_start)) w_state_nxt = ST_CONV;
            end
            ST_CONV: begin
                if (w_frame_done) w_state_nxt = ST_QUIET;
            end
            ST_QUIET: begin
                if (r_quiet_cnt == Q_LAST) begin
                    w_state_nxt = (i_en && !i_single) ? ST_CONV : ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= ST_IDLE;
            r_bit_cnt   <= '0;
            r_quiet_cnt <= '0;
            r_valid     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_valid <= w_frame_done;
            if (r_state != ST_CONV) begin
                r_bit_cnt <= '0;
            end else if (w_rise_tick) begin
                r_bit_cnt <= r_bit_cnt + 1'b1;
            end
            if (r_state != ST_QUIET) begin
                r_quiet_cnt <= '0;
            end else begin
                r_quiet_cnt <= r_quiet_cnt + 1'b1;
            end
        end
    end

    // Per channel: shift on rising SCLK; the register keeps only the low
    // DATA_BITS, so leading frame bits fall off the top.
    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        logic [DATA_BITS-1:0] r_shift;
        logic [DATA_BITS-1:0] r_prev;
        logic [DATA_BITS-1:0] r_sample;
        logic                 r_hit;
        logic                 w_hit;

        assign w_hit = (r_shift >= i_thresh) && (r_prev < i_thresh);

        always_ff @(posedge i_clk) begin
            if (i_rst) begin
                r_shift  <= '0;
                r_prev   <= '0;
                r_sample <= '0;
                r_hit    <= 1'b0;
            end else begin
                if (w_rise_tick) begin
                    r_shift <= {r_shift[DATA_BITS-2:0], i_sdata[g]};
                end
                if (w_frame_done) begin
                    r_sample <= r_shift;
                    r_prev   <= r_shift;
                    r_hit    <= w_hit;
                end else begin
                    r_hit    <= 1'b0;
                end
            end
        end

        assign o_data[g*DATA_BITS +: DATA_BITS] = r_sample;
        assign o_hit[g]                         = r_hit;
    end

    // VALID is a one-cycle strobe with no back-pressure: DATA and HIT are
    // meaningful in the VALID cycle and DATA holds until the next strobe.
    assign o_cs        = (r_state != ST_CONV);
    assign o_sclk      = w_sclk;
    assign o_valid     = r_valid;
    assign o_busy      = (r_state != ST_IDLE);
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_pmod_adc_multi_reader.sv
// Bench for pmod_adc_multi_reader: a 2-channel instance runs directed modes,
// a 4-channel instance at SCLK_HALF=1 runs continuously alongside it.
import pmod_adc_pkg::*;

module tb_pmod_adc_multi_reader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- 2-channel instance ----------------
    logic        rst = 1'b1, en = 1'b0, single = 1'b0, start = 1'b0;
    logic [1:0]  sdata = '0;
    logic [11:0] thresh = 12'h800;
    logic        cs, sclk, valid, busy;
    logic [23:0] data;
    logic [1:0]  hit, st;

    pmod_adc_multi_reader #(
        .N_CH(2), .SCLK_HALF(2), .FRAME_BITS(16), .DATA_BITS(12), .QUIET_CYC(4)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_en(en), .i_single(single), .i_start(start),
        .i_sdata(sdata), .i_thresh(thresh), .o_cs(cs), .o_sclk(sclk),
        .o_data(data), .o_valid(valid), .o_busy(busy), .o_hit(hit),
        .o_dbg_state(st)
    );

    // ---------------- 4-channel instance ----------------
    logic        rst4 = 1'b1, en4 = 1'b0, single4 = 1'b0, start4 = 1'b0;
    logic [3:0]  sdata4 = '0;
    logic [11:0] thresh4 = 12'h500;
    logic        cs4, sclk4, valid4, busy4;
    logic [47:0] data4;
    logic [3:0]  hit4;
    logic [1:0]  st4;

    pmod_adc_multi_reader #(
        .N_CH(4), .SCLK_HALF(1), .FRAME_BITS(16), .DATA_BITS(12), .QUIET_CYC(4)
    ) dut4 (
        .i_clk(clk), .i_rst(rst4), .i_en(en4), .i_single(single4), .i_start(start4),
        .i_sdata(sdata4), .i_thresh(thresh4), .o_cs(cs4), .o_sclk(sclk4),
        .o_data(data4), .o_valid(valid4), .o_busy(busy4), .o_hit(hit4),
        .o_dbg_state(st4)
    );

    // ---------------- ADC model + scoreboard, 2 channels ----------------
    logic [15:0] w0_q[$];
    logic [15:0] w1_q[$];
    logic [15:0] cur[2];
    logic [11:0] prev_m[2] = '{12'h000, 12'h000};
    logic [25:0] exp_q[$];
    logic        prev_cs = 1'b1, prev_sclk = 1'b1;
    int          bit_idx = 0, t0 = 0, frame_cnt = 0, valid_cnt = 0;
    int          hit0_cnt = 0, hit1_cnt = 0;
    logic [7:0]  hit_hist = '0;

    always @(negedge clk) begin
        logic [1:0]  hv;
        logic [25:0] e;
        if (prev_cs && !cs) begin
            cur[0] = 16'h0ABC;
            cur[1] = 16'h0FFF;
            if (w0_q.size() > 0) cur[0] = w0_q.pop_front();
            if (w1_q.size() > 0) cur[1] = w1_q.pop_front();
            for (int c = 0; c < 2; c++) begin
                hv[c]     = (cur[c][11:0] >= thresh) && (prev_m[c] < thresh);
                prev_m[c] = cur[c][11:0];
            end
            exp_q.push_back({hv, cur[1][11:0], cur[0][11:0]});
            t0 = cyc;
            bit_idx = 0;
            frame_cnt++;
        end
        if (prev_sclk && !sclk && !cs && bit_idx < 16) begin
            sdata[0] = cur[0][15-bit_idx];
            sdata[1] = cur[1][15-bit_idx];
            bit_idx++;
        end
        if (valid) begin
            valid_cnt++;
            check("valid_latency", 64'(cyc - t0), 64'd65);
            check("cs_high_at_valid", 64'(cs), 64'd1);
            if (exp_q.size() == 0) begin
                check("valid_unexpected", 64'(exp_q.size()), 64'd1);
            end else begin
                e = exp_q.pop_front();
                check("data", 64'(data), 64'(e[23:0]));
                check("hit", 64'(hit), 64'(e[25:24]));
            end
            if (hit[0]) hit0_cnt++;
            if (hit[1]) hit1_cnt++;
            hit_hist = {hit_hist[6:0], hit[0]};
        end else if (hit != 2'b00) begin
            check("hit_without_valid", 64'(hit), 64'd0);
        end
        prev_cs   = cs;
        prev_sclk = sclk;
    end

    // ---------------- ADC model + scoreboard, 4 channels ----------------
    logic [15:0] w4[4] = '{16'hE123, 16'h7456, 16'h3789, 16'h9ABC};
    logic [11:0] prev4_m[4] = '{12'h000, 12'h000, 12'h000, 12'h000};
    logic [51:0] exp4_q[$];
    logic        prev_cs4 = 1'b1, prev_sclk4 = 1'b1, have_t4 = 1'b0;
    int          bit4_idx = 0, t4 = 0, valid4_cnt = 0;

    always @(negedge clk) begin
        logic [3:0]  hv;
        logic [51:0] e;
        if (prev_cs4 && !cs4) begin
            for (int c = 0; c < 4; c++) begin
                hv[c]      = (w4[c][11:0] >= thresh4) && (prev4_m[c] < thresh4);
                prev4_m[c] = w4[c][11:0];
            end
            exp4_q.push_back({hv, w4[3][11:0], w4[2][11:0], w4[1][11:0], w4[0][11:0]});
            if (have_t4) check("w4_period", 64'(cyc - t4), 64'd37);
            have_t4  = 1'b1;
            t4       = cyc;
            bit4_idx = 0;
        end
        if (prev_sclk4 && !sclk4 && !cs4 && bit4_idx < 16) begin
            for (int c = 0; c < 4; c++) sdata4[c] = w4[c][15-bit4_idx];
            bit4_idx++;
        end
        if (valid4) begin
            valid4_cnt++;
            check("w4_latency", 64'(cyc - t4), 64'd33);
            if (exp4_q.size() == 0) begin
                check("w4_valid_unexpected", 64'(exp4_q.size()), 64'd1);
            end else begin
                e = exp4_q.pop_front();
                check("w4_data", 64'(data4), 64'(e[47:0]));
                check("w4_hit", 64'(hit4), 64'(e[51:48]));
            end
        end
        prev_cs4   = cs4;
        prev_sclk4 = sclk4;
    end

    // ---------------- bounded waits ----------------
    task automatic wait_frames(input string tag, input int n, input int budget);
        for (int i = 0; i < budget && frame_cnt < n; i++) tick();
        check(tag, 64'(frame_cnt >= n), 64'd1);
    endtask

    task automatic wait_valids(input string tag, input int n, input int budget);
        for (int i = 0; i < budget && valid_cnt < n; i++) tick();
        check(tag, 64'(valid_cnt >= n), 64'd1);
    endtask

    task automatic wait_idle(input string tag, input int budget);
        for (int i = 0; i < budget && (busy || st != ST_IDLE); i++) tick();
        check(tag, 64'(!busy && st == ST_IDLE), 64'd1);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        int f0, v0, h0, h1, ta, bad;

        // Reset
        tick();
        tick();
        check("rst_cs", 64'(cs), 64'd1);
        check("rst_sclk", 64'(sclk), 64'd1);
        check("rst_data", 64'(data), 64'd0);
        check("rst_valid", 64'(valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_hit", 64'(hit), 64'd0);
        check("rst_state", 64'(st), 64'(ST_IDLE));
        check("rst4_data", 64'(data4), 64'd0);
        rst  = 1'b0;
        rst4 = 1'b0;
        tick();
        check("idle_no_en_cs", 64'(cs), 64'd1);

        // Continuous capture, with the 4-channel instance free-running
        en  = 1'b1;
        en4 = 1'b1;
        f0  = frame_cnt;
        wait_frames("cont_first_frame", f0 + 1, 20);
        ta = t0;
        wait_frames("cont_second_frame", f0 + 2, 200);
        check("cont_period", 64'(t0 - ta), 64'd69);
        check("cont_data_hold", 64'(data), 64'h000FFFABC);
        en = 1'b0;
        wait_idle("cont_stop_idle", 200);

        // EN dropped mid-frame: frame completes, then IDLE with CS/SCLK parked
        en = 1'b1;
        f0 = frame_cnt;
        v0 = valid_cnt;
        wait_frames("endrop_frame", f0 + 1, 20);
        while (cyc < t0 + 30) tick();
        en = 1'b0;
        wait_valids("endrop_valid", v0 + 1, 100);
        wait_idle("endrop_idle", 20);
        bad = 0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (!(cs && sclk)) bad++;
        end
        check("endrop_steady", 64'(bad), 64'd0);
        check("endrop_frames", 64'(frame_cnt - f0), 64'd1);

        // Single-shot: extra START in CONV and in QUIET is ignored
        single = 1'b1;
        en     = 1'b1;
        f0 = frame_cnt;
        v0 = valid_cnt;
        pulse_start();
        repeat (20) tick();
        check("ss_busy_in_conv", 64'(busy), 64'd1);
        pulse_start();
        wait_valids("ss_valid", v0 + 1, 100);
        pulse_start();
        wait_idle("ss_idle", 20);
        repeat (100) tick();
        check("ss_frames", 64'(frame_cnt - f0), 64'd1);
        check("ss_valids", 64'(valid_cnt - v0), 64'd1);
        check("ss_busy_after", 64'(busy), 64'd0);

        // Hit detection, one single-shot frame per sample
        h0 = hit0_cnt;
        h1 = hit1_cnt;
        foreach (w4[k]) begin end
        for (int k = 0; k < 5; k++) begin
            case (k)
                0: w0_q.push_back(16'h0100);
                1: w0_q.push_back(16'h0900);
                2: w0_q.push_back(16'h0A00);
                3: w0_q.push_back(16'h0100);
                default: w0_q.push_back(16'h0850);
            endcase
            w1_q.push_back(16'h0000);
            pulse_start();
            wait_idle("hit_frame_idle", 150);
        end
        check("hit0_count", 64'(hit0_cnt - h0), 64'd2);
        check("hit0_pattern", 64'(hit_hist[4:0]), 64'b01001);
        check("hit1_count", 64'(hit1_cnt - h1), 64'd0);

        // Reset mid-frame aborts cleanly; prev samples are cleared
        single = 1'b0;
        f0 = frame_cnt;
        wait_frames("rstmid_frame", f0 + 1, 20);
        while (cyc < t0 + 40) tick();
        rst = 1'b1;
        en  = 1'b0;
        exp_q.delete();
        prev_m[0] = '0;
        prev_m[1] = '0;
        v0 = valid_cnt;
        tick();
        rst = 1'b0;
        check("rstmid_cs", 64'(cs), 64'd1);
        check("rstmid_sclk", 64'(sclk), 64'd1);
        check("rstmid_data", 64'(data), 64'd0);
        check("rstmid_valid", 64'(valid), 64'd0);
        check("rstmid_state", 64'(st), 64'(ST_IDLE));
        repeat (40) tick();
        check("rstmid_no_valid", 64'(valid_cnt - v0), 64'd0);
        h0 = hit0_cnt;
        w0_q.push_back(16'h0900);
        w1_q.push_back(16'h0000);
        single = 1'b1;
        en     = 1'b1;
        pulse_start();
        wait_idle("rstmid_fresh_idle", 150);
        check("rstmid_fresh_valid", 64'(valid_cnt - v0), 64'd1);
        check("rstmid_fresh_hit", 64'(hit0_cnt - h0), 64'd1);
        check("rstmid_fresh_data", 64'(data), 64'h000000900);

        // Wind down the 4-channel instance
        en4 = 1'b0;
        for (int i = 0; i < 100 && (busy4 || st4 != ST_IDLE); i++) tick();
        check("w4_idle", 64'(!busy4 && st4 == ST_IDLE), 64'd1);
        check("w4_frames_seen", 64'(valid4_cnt >= 3), 64'd1);
        check("w4_final_data", 64'(data4), 64'hABC789456123);
        check("exp_q_drained", 64'(exp_q.size()), 64'd0);
        check("exp4_q_drained", 64'(exp4_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
